// File: rtl/atc_pkg.sv
// atc_pkg: shared mode encoding, beat metadata and helpers for the approximate tree compressor
package atc_pkg;
  typedef enum logic [1:0] {
    ATC_APPROX = 2'd0,
    ATC_VCOMP  = 2'd1,
    ATC_EXACT  = 2'd2
  } atc_mode_t;
  typedef struct packed {
    logic      valid;
    atc_mode_t mode;
  } atc_meta_t;
  function automatic int unsigned popcount(input logic [63:0] x);
    popcount = 0;
    for (int i = 0; i < 64; i++) popcount += 32'(x[i]);
  endfunction
  // reserved mode 3 is folded onto APPROX at the pipe entry so later stages only see legal modes
  function automatic atc_meta_t atc_meta(input logic valid, input logic [1:0] mode);
    return '{valid: valid, mode: (mode == 2'd3) ? ATC_APPROX : atc_mode_t'(mode)};
  endfunction
endpackage

// File: rtl/atc_level.sv
// atc_level: one registered level of pairwise OR/AND compression with error accumulation
module atc_level
  import atc_pkg::*;
#(
  parameter int W     = 11,
  parameter int ROWS  = 8,
  parameter int OUT_W = 14,
  parameter int CNT_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adv,
  input  logic                       prev_valid,
  input  logic [1:0]                 prev_mode,
  input  logic [ROWS-1:0][W-1:0]     prev_rows,
  input  logic [W-1:0]               prev_v,
  input  logic [CNT_W-1:0]           prev_cnt,
  input  logic [OUT_W-1:0]           prev_q,
  output logic                       valid,
  output logic [1:0]                 mode,
  output logic [ROWS/2-1:0][W-1:0]   rows,
  output logic [W-1:0]               v,
  output logic [CNT_W-1:0]           cnt,
  output logic [OUT_W-1:0]           q
);
  logic [ROWS/2-1:0][W-1:0] p_n;
  logic [W-1:0]             q_i;
  logic [W-1:0]             q_or;
  logic [CNT_W-1:0]         q_pop;
  logic [OUT_W-1:0]         q_sum;
  // compress rows 2i/2i+1 into row i; the dropped AND terms feed the error accumulators
  always_comb begin
    p_n = '0;
    q_i = '0;
    q_or = '0;
    q_pop = '0;
    q_sum = '0;
    for (int i = 0; i < ROWS / 2; i++) begin
      p_n[i] = prev_rows[2*i] | prev_rows[2*i+1];
      q_i    = prev_rows[2*i] & prev_rows[2*i+1];
      q_or   = q_or | q_i;
      q_pop  = q_pop + CNT_W'(popcount(64'(q_i)));
      q_sum  = q_sum + OUT_W'(q_i);
    end
  end
  // level register: loads bubbles too on advance, holds everything on a global stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      mode  <= '0;
      rows  <= '0;
      v     <= '0;
      cnt   <= '0;
      q     <= '0;
    end else if (adv) begin
      valid <= prev_valid;
      mode  <= prev_mode;
      rows  <= p_n;
      v     <= prev_v | q_or;
      cnt   <= prev_cnt + q_pop;
      q     <= prev_q + q_sum;
    end
  end
endmodule

// File: rtl/atc_pipe.sv
// atc_pipe: pipelined approximate tree compressor with per-beat approx/vcomp/exact result
module atc_pipe
  import atc_pkg::*;
#(
  parameter  int WORD_SIZE = 11,
  parameter  int PP_NUM    = 8,
  localparam int OUT_W     = WORD_SIZE + $clog2(PP_NUM),
  localparam int CNT_W     = $clog2(WORD_SIZE * PP_NUM / 2 + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       mode,
  input  logic [PP_NUM-1:0][WORD_SIZE-1:0] D,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [1:0][WORD_SIZE-1:0]        P,
  output logic [WORD_SIZE-1:0]             V,
  output logic [CNT_W-1:0]                 err_cnt,
  output logic [OUT_W-1:0]                 sum
);
  localparam int L   = $clog2(PP_NUM) - 1;
  localparam int TOP = 2 * PP_NUM - 4;
  logic                                 adv;
  atc_meta_t                            m0;
  logic [2*PP_NUM-3:0][WORD_SIZE-1:0]   tree;
  logic [L:0]                           valid_s;
  logic [L:0][1:0]                      mode_s;
  logic [L:0][WORD_SIZE-1:0]            v_s;
  logic [L:0][CNT_W-1:0]                cnt_s;
  logic [L:0][OUT_W-1:0]                q_s;
  logic [OUT_W-1:0]                     base;
  assign adv        = out_ready | ~out_valid;
  assign in_ready   = adv;
  assign m0         = atc_meta(in_valid, mode);
  assign tree[PP_NUM-1:0] = D;
  assign valid_s[0] = m0.valid;
  assign mode_s[0]  = m0.mode;
  assign v_s[0]     = '0;
  assign cnt_s[0]   = '0;
  assign q_s[0]     = '0;
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int ROWS = PP_NUM >> k;
    localparam int OFF  = 2 * PP_NUM - 2 * ROWS;
    atc_level #(.W(WORD_SIZE), .ROWS(ROWS), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_lvl (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv),
      .prev_valid (valid_s[k]),
      .prev_mode  (mode_s[k]),
      .prev_rows  (tree[OFF +: ROWS]),
      .prev_v     (v_s[k]),
      .prev_cnt   (cnt_s[k]),
      .prev_q     (q_s[k]),
      .valid      (valid_s[k+1]),
      .mode       (mode_s[k+1]),
      .rows       (tree[OFF+ROWS +: ROWS/2]),
      .v          (v_s[k+1]),
      .cnt        (cnt_s[k+1]),
      .q          (q_s[k+1])
    );
  end
  assign base = OUT_W'(tree[TOP]) + OUT_W'(tree[TOP+1]);
  // final add stage: adding q_acc back restores the exact sum, adding V is the cheap compensation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      P         <= '0;
      V         <= '0;
      err_cnt   <= '0;
      sum       <= '0;
    end else if (adv) begin
      out_valid <= valid_s[L];
      P         <= tree[TOP +: 2];
      V         <= v_s[L];
      err_cnt   <= cnt_s[L];
      sum       <= atc_mode_t'(mode_s[L]) == ATC_VCOMP ? base + OUT_W'(v_s[L]) :
                   atc_mode_t'(mode_s[L]) == ATC_EXACT ? base + q_s[L] : base;
    end
  end
endmodule

// File: tb/tb_atc_pipe.sv
// tb_atc_pipe: directed checks of atc_pipe at PP_NUM=4 and PP_NUM=8 with WORD_SIZE=4
module tb_atc_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv4 = 1'b0, ir4, ov4, or4 = 1'b1;
  logic [1:0] md4 = '0;
  logic [3:0][3:0] d4 = '0;
  logic [1:0][3:0] p4;
  logic [3:0] v4;
  logic [3:0] c4;
  logic [5:0] s4;
  logic iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
  logic [1:0] md8 = '0;
  logic [7:0][3:0] d8 = '0;
  logic [1:0][3:0] p8;
  logic [3:0] v8;
  logic [4:0] c8;
  logic [6:0] s8;
  int tests = 0;
  int fails = 0;
  logic [15:0] bd [5] = '{16'h1111, 16'h1111, 16'h1111, 16'h0053, 16'h8421};
  logic [1:0]  bm [5] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
  int          es [5] = '{2, 3, 4, 8, 15};

  atc_pipe #(.WORD_SIZE(4), .PP_NUM(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .mode(md4), .D(d4),
    .out_valid(ov4), .out_ready(or4), .P(p4), .V(v4), .err_cnt(c4), .sum(s4)
  );
  atc_pipe #(.WORD_SIZE(4), .PP_NUM(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .mode(md8), .D(d8),
    .out_valid(ov8), .out_ready(or8), .P(p8), .V(v8), .err_cnt(c8), .sum(s8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic send4(input logic [15:0] d, input logic [1:0] m, output int lat);
    @(negedge clk);
    iv4 = 1'b1; d4 = d; md4 = m;
    @(posedge clk); #1;
    iv4 = 1'b0; d4 = '0; md4 = 2'd2;
    lat = 1;
    while (!ov4 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send8(input logic [31:0] d, input logic [1:0] m, output int lat);
    @(negedge clk);
    iv8 = 1'b1; d8 = d; md8 = m;
    @(posedge clk); #1;
    iv8 = 1'b0; d8 = '0; md8 = 2'd0;
    lat = 1;
    while (!ov8 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL reset ov4 got %0b exp 0", ov4); end
    tests++; if (s4 !== 6'd0) begin fails++; $display("FAIL reset s4 got %0d exp 0", s4); end
    tests++; if (ir4 !== 1'b1) begin fails++; $display("FAIL reset ir4 got %0b exp 1", ir4); end
    tests++; if (ov8 !== 1'b0) begin fails++; $display("FAIL reset ov8 got %0b exp 0", ov8); end
    tests++; if (s8 !== 7'd0) begin fails++; $display("FAIL reset s8 got %0d exp 0", s8); end
    tests++; if (ir8 !== 1'b1) begin fails++; $display("FAIL reset ir8 got %0b exp 1", ir8); end
  endtask

  task automatic test_mode_sweep;
    int lat;
    int exp_s;
    for (int m = 0; m < 4; m++) begin
      send4(16'h1111, 2'(m), lat);
      exp_s = (m == 1) ? 3 : (m == 2) ? 4 : 2;
      tests++; if (lat !== 2) begin fails++; $display("FAIL sweep m%0d latency got %0d exp 2", m, lat); end
      tests++; if (s4 !== 6'(exp_s)) begin fails++; $display("FAIL sweep m%0d sum got %0d exp %0d", m, s4, exp_s); end
      tests++; if (v4 !== 4'd1) begin fails++; $display("FAIL sweep m%0d V got %0d exp 1", m, v4); end
      tests++; if (c4 !== 4'd2) begin fails++; $display("FAIL sweep m%0d err_cnt got %0d exp 2", m, c4); end
      tests++; if (p4 !== 8'h11) begin fails++; $display("FAIL sweep m%0d P got %h exp 11", m, p4); end
    end
  endtask

  task automatic test_carry;
    int lat;
    int exp_s;
    for (int m = 0; m < 3; m++) begin
      send4(16'h0053, 2'(m), lat);
      exp_s = (m == 0) ? 7 : 8;
      tests++; if (s4 !== 6'(exp_s)) begin fails++; $display("FAIL carry m%0d sum got %0d exp %0d", m, s4, exp_s); end
      tests++; if (p4 !== 8'h07) begin fails++; $display("FAIL carry m%0d P got %h exp 07", m, p4); end
      tests++; if (v4 !== 4'd1 || c4 !== 4'd1) begin fails++; $display("FAIL carry m%0d V/cnt got %0d/%0d exp 1/1", m, v4, c4); end
    end
  endtask

  task automatic test_disjoint;
    int lat;
    for (int m = 0; m < 3; m++) begin
      send4(16'h8421, 2'(m), lat);
      tests++; if (s4 !== 6'd15) begin fails++; $display("FAIL disjoint m%0d sum got %0d exp 15", m, s4); end
      tests++; if (v4 !== 4'd0 || c4 !== 4'd0) begin fails++; $display("FAIL disjoint m%0d V/cnt got %0d/%0d exp 0/0", m, v4, c4); end
    end
    send4(16'h0000, 2'd1, lat);
    tests++; if (s4 !== 6'd0 || v4 !== 4'd0 || c4 !== 4'd0) begin fails++; $display("FAIL zero sum/V/cnt got %0d/%0d/%0d exp 0/0/0", s4, v4, c4); end
  endtask

  task automatic test_pp8;
    int lat;
    send8(32'hFFFF_FFFF, 2'd2, lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL pp8 latency got %0d exp 3", lat); end
    tests++; if (s8 !== 7'd120) begin fails++; $display("FAIL pp8 exact sum got %0d exp 120", s8); end
    tests++; if (c8 !== 5'd24) begin fails++; $display("FAIL pp8 err_cnt got %0d exp 24", c8); end
    tests++; if (v8 !== 4'hF || p8 !== 8'hFF) begin fails++; $display("FAIL pp8 V/P got %h/%h exp f/ff", v8, p8); end
    send8(32'hFFFF_FFFF, 2'd0, lat);
    tests++; if (s8 !== 7'd30) begin fails++; $display("FAIL pp8 approx sum got %0d exp 30", s8); end
  endtask

  task automatic test_back_to_back;
    int ii = 0;
    int oi = 0;
    logic acc, tk;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      or4 = (cyc >= 3 && cyc <= 5) ? 1'b0 : 1'b1;
      #1;
      if (!or4 && ov4) begin
        tests++; if (ir4 !== 1'b0) begin fails++; $display("FAIL stall in_ready cyc%0d got %0b exp 0", cyc, ir4); end
        tests++; if (oi >= 5 || s4 !== 6'(es[oi])) begin fails++; $display("FAIL stall hold cyc%0d got %0d beat %0d", cyc, s4, oi); end
      end
      iv4 = (ii < 5);
      if (ii < 5) begin d4 = bd[ii]; md4 = bm[ii]; end
      acc = iv4 && ir4;
      tk  = ov4 && or4;
      if (tk) begin
        tests++;
        if (oi >= 5) begin fails++; $display("FAIL b2b extra beat sum %0d", s4); end
        else if (s4 !== 6'(es[oi])) begin fails++; $display("FAIL b2b beat%0d sum got %0d exp %0d", oi, s4, es[oi]); end
        oi++;
      end
      @(posedge clk);
      if (acc) ii++;
    end
    #1;
    iv4 = 1'b0; or4 = 1'b1;
    tests++; if (oi !== 5) begin fails++; $display("FAIL b2b beat count got %0d exp 5", oi); end
  endtask

  task automatic test_reset_midstream;
    int lat;
    bit seen = 0;
    @(negedge clk);
    iv4 = 1'b1; d4 = 16'h1111; md4 = 2'd2;
    @(posedge clk); #1;
    d4 = 16'h0053; md4 = 2'd1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    tests++; if (ov4 !== 1'b1 || s4 !== 6'd4) begin fails++; $display("FAIL midrst inflight got %0b/%0d exp 1/4", ov4, s4); end
    rst = 1'b1;
    #1;
    tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL midrst ov4 got %0b exp 0", ov4); end
    tests++; if (s4 !== 6'd0 || p4 !== 8'h00 || v4 !== 4'd0 || c4 !== 4'd0) begin fails++; $display("FAIL midrst outputs got %0d/%h/%0d/%0d exp 0", s4, p4, v4, c4); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ov4) seen = 1;
    end
    tests++; if (seen) begin fails++; $display("FAIL midrst stray out_valid got 1 exp 0"); end
    send4(16'h0053, 2'd1, lat);
    tests++; if (lat !== 2 || s4 !== 6'd8) begin fails++; $display("FAIL midrst next beat lat/sum got %0d/%0d exp 2/8", lat, s4); end
  endtask

  initial begin
    test_reset();
    test_mode_sweep();
    test_carry();
    test_disjoint();
    test_pp8();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
